// File: rtl/l2k_pkg.sv
// Shared definitions for the l2k direct-mapped cache controller: FSM state
// encodings and the address index/tag split.
package l2k_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOOKUP = 3'd1;
  localparam state_t ST_FILL   = 3'd2;
  localparam state_t ST_WRITE  = 3'd3;
  localparam state_t ST_FLUSH  = 3'd4;

  // Word index: addr[2+idx_w-1:2], returned right-aligned.
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w);
    return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag: addr[31:2+idx_w], returned right-aligned.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
    return addr >> (2 + idx_w);
  endfunction

endpackage

// File: rtl/l2k_tag_ram.sv
// Tag and valid storage for the l2k cache: combinational read, one write
// port, single-index valid clear for the flush walk.
module l2k_tag_ram #(
  parameter int IDX_W = 9,
  parameter int TAG_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tags [DEPTH];

  assign rd_tag   = tags[rd_idx];
  assign rd_valid = valid[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (clr_en) valid[clr_idx] <= 1'b0;
      if (wr_en)  valid[wr_idx]  <= 1'b1;
    end
  end

  // NOTE: only the valid bits are reset; tag contents are meaningless while
  // valid is clear, so the tag array stays a plain reset-free memory.
  always_ff @(posedge clk) begin
    if (wr_en) tags[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/l2k_cache_ctrl.sv
// Direct-mapped, write-through / write-allocate cache controller with two
// round-robin arbitrated ports, an external data array and a flush walker.
module l2k_cache_ctrl
  import l2k_pkg::*;
#(
  parameter  int NUM_ENTRIES = 512,
  parameter  int DATA_WIDTH  = 32,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic [31:0]           p0_addr,
  output logic                  p0_rdy,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [31:0]           p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rdy,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  arr_we,
  output logic [IDX_W-1:0]      arr_idx,
  output logic [DATA_WIDTH-1:0] arr_wdata,
  input  logic [DATA_WIDTH-1:0] arr_rdata,
  input  logic                  flush,
  output logic                  busy
);

  localparam int TAG_W = 30 - IDX_W;

  state_t                state;
  logic                  pending;
  logic                  rr_p1_last;
  logic                  gnt_p1;
  logic                  l_we;
  logic [31:0]           l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic [IDX_W-1:0]      flush_cnt;

  logic [IDX_W-1:0]      l_idx;
  logic [TAG_W-1:0]      l_tag;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_valid;
  logic                  hit;
  logic                  pick_p1;
  logic                  done_rd;
  logic                  done_wr;
  logic [DATA_WIDTH-1:0] rd_word;

  assign l_idx     = IDX_W'(addr_index(l_addr, IDX_W));
  assign l_tag     = TAG_W'(addr_tag(l_addr, IDX_W));
  assign hit       = rd_valid && (rd_tag == l_tag);
  assign pick_p1   = p1_req && (!p0_req || !rr_p1_last);
  assign busy      = (state != ST_IDLE);
  assign arr_idx   = l_idx;
  assign arr_we    = ((state == ST_FILL) || (state == ST_WRITE)) && mem_ack;
  assign arr_wdata = (state == ST_WRITE) ? l_wdata : mem_rdata;

  // NOTE: every signal gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    done_rd = 1'b0;
    done_wr = 1'b0;
    rd_word = arr_rdata;
    case (state)
      ST_LOOKUP: done_rd = !l_we && hit;
      ST_FILL: begin
        done_rd = mem_ack;
        rd_word = mem_rdata;
      end
      ST_WRITE: done_wr = mem_ack;
      default: ;
    endcase
  end

  l2k_tag_ram #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_tag_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (l_idx),
    .rd_tag  (rd_tag),
    .rd_valid(rd_valid),
    .wr_en   (arr_we),
    .wr_idx  (l_idx),
    .wr_tag  (l_tag),
    .clr_en  (state == ST_FLUSH),
    .clr_idx (flush_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      rr_p1_last <= 1'b1;
      gnt_p1     <= 1'b0;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      flush_cnt  <= '0;
      p0_rdy     <= 1'b0;
      p1_rdy     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments; a later assignment in this block to
      // the same register overrides these defaults for the same edge.
      p0_rdy <= 1'b0;
      p1_rdy <= 1'b0;
      if (flush) pending <= 1'b1;

      if (done_rd) begin
        if (gnt_p1) begin
          p1_rdata <= rd_word;
          p1_rdy   <= 1'b1;
        end else begin
          p0_rdata <= rd_word;
          p0_rdy   <= 1'b1;
        end
      end
      if (done_wr) p1_rdy <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (pending) begin
            pending   <= flush;   // a flush in this very cycle earns another walk
            flush_cnt <= '0;
            state     <= ST_FLUSH;
          end else if (p0_req || p1_req) begin
            gnt_p1     <= pick_p1;
            rr_p1_last <= pick_p1;
            l_addr     <= pick_p1 ? p1_addr : p0_addr;
            l_we       <= pick_p1 && p1_we;
            l_wdata    <= p1_wdata;
            state      <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (l_we || !hit) begin
            mem_req   <= 1'b1;
            mem_we    <= l_we;
            mem_addr  <= l_addr & ~32'h3;
            mem_wdata <= l_wdata;
            state     <= l_we ? ST_WRITE : ST_FILL;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FILL, ST_WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + IDX_W'(1);
          if (&flush_cnt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2k_cache_ctrl.sv
// Self-checking bench for l2k_cache_ctrl: table-driven accesses with a read
// scoreboard, plus hand sequences for arbitration, flush and reset corners.
module tb_l2k_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p1_req, p1_we, flush;
  logic [31:0] p0_addr, p1_addr, p1_wdata;
  logic        p0_rdy, p1_rdy;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        arr_we;
  logic [8:0]  arr_idx;
  logic [31:0] arr_wdata, arr_rdata;
  logic        busy;

  always #5 clk = ~clk;

  l2k_cache_ctrl #(.NUM_ENTRIES(512), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_rdy(p0_rdy), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdy(p1_rdy), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .arr_we(arr_we), .arr_idx(arr_idx), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .flush(flush), .busy(busy)
  );

  // External data array: combinational read, clocked write.
  logic [31:0] arr_mem [512];
  assign arr_rdata = arr_mem[arr_idx];
  always @(posedge clk) if (arr_we) arr_mem[arr_idx] <= arr_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference memory (updated from stimulus) and the responder's memory.
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] word_default(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a & ~32'h3) ? ref_mem[a & ~32'h3] : word_default(a & ~32'h3);
  endfunction

  // Backing-memory responder: ack after mem_lat waiting cycles.
  int mem_lat = 1;
  int wait_cnt = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_ack) begin
        if (wait_cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : word_default(mem_addr);
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard: expectations pushed at issue, popped on each rdy pulse.
  typedef struct {
    bit          port;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (p0_rdy || p1_rdy)) begin
        check("rdy_onehot", 32'(p0_rdy & p1_rdy), 32'd0);
        if (sb.size() == 0) begin
          check("sb_unexpected_rdy", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("sb_port", 32'(p1_rdy), 32'(e.port));
          if (e.chk_data) check("sb_rdata", p1_rdy ? p1_rdata : p0_rdata, e.data);
        end
      end
    end
  end

  task automatic reset_dut();
    rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0; flush = 1'b0;
    p0_addr = '0; p1_addr = '0; p1_wdata = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One access through a port; checks completion, hit latency or miss bus use.
  task automatic do_access(input string name, input bit port, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input bit exp_hit);
    int cycles = 0;
    bit got = 0, saw_mem = 0, m_we = 0;
    logic [31:0] m_addr = '0, m_wd = '0;
    exp_t e;
    e.port = port; e.chk_data = !we; e.data = ref_rd(addr);
    sb.push_back(e);
    if (we) ref_mem[addr & ~32'h3] = wdata;
    mem_lat = lat;
    @(negedge clk);
    if (port) begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    else      begin p0_req = 1'b1; p0_addr = addr; end
    while (!got && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (mem_req) begin saw_mem = 1; m_addr = mem_addr; m_we = mem_we; m_wd = mem_wdata; end
      got = port ? p1_rdy : p0_rdy;
    end
    p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
    check({name, "_done"}, 32'(got), 32'd1);
    if (exp_hit) begin
      check({name, "_hit_lat"}, 32'(cycles), 32'd2);
      check({name, "_hit_nomem"}, 32'(saw_mem), 32'd0);
    end else begin
      check({name, "_miss_mem"}, 32'(saw_mem), 32'd1);
      check({name, "_mem_addr"}, m_addr, addr & ~32'h3);
      check({name, "_mem_we"}, 32'(m_we), 32'(we));
      if (we) check({name, "_mem_wdata"}, m_wd, wdata);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          exp_hit;
  } vec_t;
  vec_t vecs[13];

  initial begin
    int n, run, busy_cnt, cycles;
    bit order[4];
    bit got;
    exp_t e;

    vecs[0]  = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,          3, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,          1, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678,  1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_2004, 32'h0,          1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          2, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0810, 32'h0,          0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,          1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,          1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_F00D,  0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,          1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_1800, 32'h0,          0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,          2, 1'b0};

    ref_mem[32'h1000]   = 32'hDEAD_BEEF;
    mem_model[32'h1000] = 32'hDEAD_BEEF;

    // Reset values, sampled while reset is held.
    rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0; flush = 1'b0;
    p0_addr = '0; p1_addr = '0; p1_wdata = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_arr_we", 32'(arr_we), 32'd0);
    check("rst_rdy", {30'd0, p1_rdy, p0_rdy}, 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_p1_rdata", p1_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset_dut();

    for (int i = 0; i < 13; i++)
      do_access($sformatf("v%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, vecs[i].lat, vecs[i].exp_hit);

    // Round-robin: both ports hold requests; grants alternate from p0.
    reset_dut();
    mem_lat = 1;
    for (int i = 0; i < 4; i++) begin
      e.port = i[0]; e.chk_data = 1'b1;
      e.data = ref_rd(i[0] ? 32'h3104 : 32'h3000);
      sb.push_back(e);
    end
    @(negedge clk);
    p0_addr = 32'h3000; p1_addr = 32'h3104; p1_we = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    n = 0;
    for (int c = 0; c < 400 && n < 4; c++) begin
      @(negedge clk);
      if (p0_rdy || p1_rdy) begin order[n] = p1_rdy; n++; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check("arb_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("arb_grant%0d", i), 32'(order[i]), 32'(i % 2));

    // Flush mid-FILL: fill completes, then a full 512-cycle walk.
    do_access("fl_pre_miss", 1'b0, 1'b0, 32'h1000, 32'h0, 1, 1'b0);
    do_access("fl_pre_hit",  1'b0, 1'b0, 32'h1000, 32'h0, 1, 1'b1);
    e.port = 1'b0; e.chk_data = 1'b1; e.data = ref_rd(32'h4000);
    sb.push_back(e);
    mem_lat = 4;
    @(negedge clk);
    p0_addr = 32'h4000; p0_req = 1'b1;
    cycles = 0;
    while (!mem_req && cycles < 20) begin @(negedge clk); cycles++; end
    check("fl_fill_started", 32'(mem_req), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    got = p0_rdy;
    cycles = 0;
    while (!got && cycles < 50) begin @(negedge clk); cycles++; got = p0_rdy; end
    p0_req = 1'b0;
    check("fl_fill_done", 32'(got), 32'd1);
    run = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) run++;
      else if (run > 0) break;
    end
    check("fl_walk_len", 32'(run), 32'd512);
    do_access("fl_post_1000", 1'b0, 1'b0, 32'h1000, 32'h0, 1, 1'b0);
    do_access("fl_post_4000", 1'b1, 1'b0, 32'h4000, 32'h0, 1, 1'b0);

    // Flush during FLUSH re-arms one further full walk.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 1200; i++) begin
      flush = (i == 100);
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    flush = 1'b0;
    check("fl_rearm_busy", 32'(busy_cnt), 32'd1024);

    // Reset mid-FILL abandons the transfer.
    mem_lat = 10;
    @(negedge clk);
    p0_addr = 32'h5000; p0_req = 1'b1;
    cycles = 0;
    while (!mem_req && cycles < 20) begin @(negedge clk); cycles++; end
    check("rf_fill_started", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rf_mem_req", 32'(mem_req), 32'd0);
    check("rf_busy", 32'(busy), 32'd0);
    check("rf_rdy", {30'd0, p1_rdy, p0_rdy}, 32'd0);
    p0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    do_access("rf_reread", 1'b0, 1'b0, 32'h5000, 32'h0, 1, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2k_cache_ctrl.md
L2K_CACHE_CTRL -- requirements
Module: l2k_cache_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 512: entry count, power of two; IDX_W = log2(NUM_ENTRIES).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data word width.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have ports p0_req in 1, p0_addr in 32, p0_rdy out 1, p0_rdata out DATA_WIDTH: instruction-side read port.
REQ-006 SHALL have ports p1_req in 1, p1_we in 1, p1_addr in 32, p1_wdata in DATA_WIDTH, p1_rdy out 1, p1_rdata out DATA_WIDTH: data-side read/write port.
REQ-007 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out DATA_WIDTH, mem_ack in 1, mem_rdata in DATA_WIDTH: backing-memory bus.
REQ-008 SHALL have ports arr_we out 1, arr_idx out IDX_W, arr_wdata out DATA_WIDTH, arr_rdata in DATA_WIDTH: external data array, combinational read, write on clk edge.
REQ-009 SHALL have ports flush in 1 (pulse, invalidate all) and busy out 1 (state != IDLE).

Function
REQ-010 SHALL split addresses as index = addr[2+IDX_W-1:2], tag = addr[31:2+IDX_W]; addr[1:0] ignored.
REQ-011 SHALL use states IDLE, LOOKUP, FILL, WRITE, FLUSH.
REQ-012 IDLE: pending flush has priority -> FLUSH; else grant one requesting port, latch its addr/we/wdata, -> LOOKUP; no request -> stay.
REQ-013 Arbitration SHALL be round-robin: with both requesting, grant the port not granted last; after reset p0 wins first.
REQ-014 LOOKUP, read, valid and tag match: rdata = arr_rdata, rdy pulse one cycle, -> IDLE (hit latency 2 cycles from req sampled in IDLE).
REQ-015 LOOKUP, read miss: -> FILL with mem_req=1, mem_we=0, mem_addr = latched addr with [1:0]=0.
REQ-016 FILL: hold mem_req and mem_addr until mem_ack; on ack cycle arr_we=1, arr_wdata=mem_rdata, tag/valid set, rdata=mem_rdata, rdy pulse, -> IDLE.
REQ-017 LOOKUP, write (p1 only): -> WRITE; write-through: mem_req=1, mem_we=1, mem_wdata=p1_wdata until mem_ack; on ack cycle array and tag/valid updated (write-allocate), p1_rdy pulse, -> IDLE.
REQ-018 Handshake: requester SHALL hold req and operands until rdy; req still high in the IDLE cycle after rdy is a new request.
REQ-019 rdy SHALL only pulse on the granted port; rdata SHALL hold its last value otherwise.
REQ-020 mem_ack outside FILL/WRITE SHALL be ignored; mem_ack may arrive in the first mem_req cycle (zero wait).
REQ-021 flush arriving in any state SHALL set a pending bit, serviced at next IDLE; in-flight access completes first.
REQ-022 FLUSH: counter walks index 0..NUM_ENTRIES-1 clearing one valid bit per cycle, clears pending, -> IDLE after the last index (NUM_ENTRIES cycles); requests wait.
REQ-023 flush during FLUSH SHALL re-arm pending, causing one further full walk.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, all valid bits 0, flush pending 0, round-robin pointer to p1-last, mem_req/mem_we/arr_we/p0_rdy/p1_rdy/busy 0, rdata/mem_addr/mem_wdata 0.
REQ-025 Reset mid-FILL/WRITE SHALL abandon the transfer; no array write and no rdy result.

Structure
REQ-026 Shared package l2k_pkg SHALL hold the state enum and address split helpers (index/tag extraction).
REQ-027 Tag and valid storage SHALL be sub-module l2k_tag_ram (combinational read, write port, per-index valid clear, async clear on rst_n).

Verification
REQ-028 Reset, p0 read 0x0000_1000, mem_rdata=0xDEAD_BEEF after 3 cycles -> miss, mem_addr=0x1000, p0_rdata=0xDEADBEEF; repeat -> hit in 2 cycles, no mem_req.
REQ-029 p0 and p1 request same cycle, repeated 4 times -> grants p0,p1,p0,p1.
REQ-030 p1 write 0x0000_2004 data 0x1234_5678, ack after 1 cycle -> mem_we=1; then p0 read 0x2004 -> hit 0x12345678.
REQ-031 Aliasing: read 0x0000_0010 then 0x0000_0810 (NUM_ENTRIES=512) -> both miss, second evicts first; re-read 0x10 misses.
REQ-032 flush asserted mid-FILL -> fill completes, FLUSH lasts 512 cycles with busy=1, all later reads miss.
REQ-033 rst_n low during FILL before mem_ack -> mem_req drops at once, no rdy, next read of same address misses.
